regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the processor register file and shares it between two writeback requesters: req0 (ALU writeback) and req1 (load/IO writeback).
- After reset, and on request, it runs a clear sequence that writes zero to every register from 1 to NREGS-1.
- After the clear it arbitrates round-robin using valid/ready handshakes.
- Sits between the datapath writeback sources and the register file.

Parameters:
- DW, 8, data width; matches wd3.
- AW, 5, address width; matches wa3.
- NREGS, 16, number of physically implemented registers. Register 0 reads as zero and is never written.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- clear, input, 1, synchronous request to re-run the clear sequence.
- req0_valid, input, 1, requester 0 has a write.
- req0_addr, input, AW, requester 0 destination register.
- req0_data, input, DW, requester 0 write data.
- req0_ready, output, 1, requester 0 write accepted this cycle.
- req1_valid, input, 1, requester 1 has a write.
- req1_addr, input, AW, requester 1 destination register.
- req1_data, input, DW, requester 1 write data.
- req1_ready, output, 1, requester 1 write accepted this cycle.
- we3, output, 1, register-file write enable; registered.
- wa3, output, AW, register-file write address; registered.
- wd3, output, DW, register-file write data; registered.
- busy, output, 1, high while in CLEAR.
- last_grant, output, 1, id of the most recently accepted requester.

Behaviour:
- Reset (async, takes effect immediately):
  - state = CLEAR, clr_cnt = 1.
  - we3 = 0, wa3 = 0, wd3 = 0.
  - last_grant = 1, so req0 has first priority.
  - busy = 1, req0_ready = req1_ready = 0.
- State CLEAR:
  - Each rising edge registers we3 = 1, wa3 = clr_cnt, wd3 = 0, then increments clr_cnt.
  - When clr_cnt == NREGS-1 is issued, the next state is ARB.
  - Exactly NREGS-1 clear writes occur, on addresses 1..NREGS-1, in ascending order.
  - Both ready outputs are held 0; requesters must hold valid, addr and data stable.
- State ARB:
  - busy = 0.
  - Grant:
    - If exactly one requester is valid, it is granted.
    - If both are valid, the one not equal to last_grant is granted.
    - The granted requester's ready is 1 combinationally in the same cycle; the other ready is 0.
    - If neither is valid, both readies are 0.
  - A transfer occurs when valid && ready.
  - On a transfer, the next edge registers we3 = 1, wa3 = addr, wd3 = data, and last_grant = the granted id.
  - With no transfer, the next edge registers we3 = 0; wa3 and wd3 hold their values.
  - Latency: acceptance at edge N puts we3 high during cycle N+1, and the register file commits at edge N+1.
  - Throughput: one write per cycle. Under sustained contention, grants strictly alternate.
- Dropped writes:
  - A write to address 0, or to any address >= NREGS, is accepted (ready = 1, last_grant updates).
  - It is dropped: the next registered we3 = 0.
- clear input:
  - clear = 1 in ARB forces both readies to 0 in that cycle.
  - No transfer occurs that cycle.
  - Next edge: state = CLEAR, clr_cnt = 1, we3 = 0.
  - clear during CLEAR restarts clr_cnt at 1.
  - clear has priority over any pending request.
- Reset mid-sequence (CLEAR or ARB): all state returns to reset values immediately. A write in flight on we3 is cancelled (we3 = 0 asynchronously).
- Arithmetic:
  - clr_cnt is AW bits wide.
  - The comparison with NREGS-1 is unsigned.
  - The address range check is unsigned: addr < NREGS.

Decomposition:
- Package regfile_pkg holds:
  - constants DW, AW, NREGS;
  - typedef enum logic {CLEAR, ARB} wr_state_t;
  - typedef logic [AW-1:0] reg_addr_t;
  - typedef logic [DW-1:0] reg_data_t.
- Sub-module rr_arb2: a combinational 2-way round-robin grant from (valid0, valid1, last_grant) producing a one-hot grant. regfile_wr_arbiter holds the last_grant flop.

Test Plan:
- Reset release, no requests → we3 = 1 for 15 consecutive cycles with wa3 = 1..15 and wd3 = 0; busy falls in the cycle after wa3 = 15; ready then asserts on the first valid.
- After clear, req0 only (addr 3, data 8'hA5) → req0_ready = 1 the same cycle; next cycle we3 = 1, wa3 = 3, wd3 = 8'hA5; then we3 = 0.
- Both valid continuously (req0 → r4 = 8'h11, req1 → r5 = 8'h22) → first grant is req0, then req1, req0, …; wa3 alternates 4, 5, 4; last_grant toggles.
- req1 writes addr 0, then addr 20 → both accepted with req1_ready = 1; we3 stays 0 for both; last_grant = 1.
- clear pulsed while both requesters are valid → both readies 0 in that cycle; next cycle busy = 1; 15 clear writes follow; the original requests are served afterwards.
- reset asserted mid-clear (at wa3 = 7) → we3, wa3 and wd3 go to 0 immediately; after release the clear restarts at wa3 = 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int NREGS = 16;

    typedef enum logic {
        CLEAR,
        ARB
    } wr_state_t;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    localparam reg_addr_t CLR_FIRST = reg_addr_t'(1);
    localparam reg_addr_t CLR_LAST  = reg_addr_t'(NREGS - 1);

    // Register 0 is hard-wired to zero and addresses past NREGS are not
    // implemented, so writes to either are accepted but never issued.
    function automatic logic addr_writable(input reg_addr_t addr);
        return (addr != '0) && (int'(addr) < NREGS);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins a tie.
module rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot grant; a lone requester always wins, a tie goes away from last_grant.
    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid0_i && (!valid1_i || last_grant_i);
        grant_o[1] = valid1_i && (!valid0_i || !last_grant_i);
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: zero-fills registers 1..NREGS-1 after
// reset or clear, then shares the port between two writeback requesters.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | issuing zero writes to clr_cnt = 1..NREGS-1, readies held low
// ARB   | round-robin grant of req0/req1, one registered write per cycle
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3,
    output logic            busy,
    output logic            last_grant
);

    wr_state_t state_q, state_d;
    reg_addr_t clr_cnt_q, clr_cnt_d;
    logic      we3_q, we3_d;
    reg_addr_t wa3_q, wa3_d;
    reg_data_t wd3_q, wd3_d;
    logic      last_grant_q, last_grant_d;

    logic [1:0] grant;
    reg_addr_t  sel_addr;
    reg_data_t  sel_data;

    rr_arb2 u_rr_arb2 (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign sel_addr = grant[1] ? req1_addr : req0_addr;
    assign sel_data = grant[1] ? req1_data : req0_data;

    // Next-state, clear sequencing, handshake and write-port selection.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            CLEAR: begin
                if (clear) begin
                    clr_cnt_d = CLR_FIRST;
                end else begin
                    we3_d     = 1'b1;
                    wa3_d     = clr_cnt_q;
                    wd3_d     = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = CLR_FIRST;
                end else begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    if (grant != 2'b00) begin
                        last_grant_d = grant[1];
                        if (addr_writable(sel_addr)) begin
                            we3_d = 1'b1;
                            wa3_d = sel_addr;
                            wd3_d = sel_data;
                        end
                    end
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = CLR_FIRST;
            end
        endcase
    end

    // State and registered write port; reset cancels any in-flight write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= CLR_FIRST;
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign busy       = (state_q == CLEAR);
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for the register-file write-port arbiter.
module tb_regfile_wr_arbiter;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       req0_valid;
    logic [4:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [4:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       we3;
    logic [4:0] wa3;
    logic [7:0] wd3;
    logic       busy;
    logic       last_grant;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .busy       (busy),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_clear_run(input string tag);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check_eq({tag, " we3"}, 32'(we3), 32'd1);
            check_eq({tag, " wa3"}, 32'(wa3), 32'(i));
            check_eq({tag, " wd3"}, 32'(wd3), 32'd0);
            check_eq({tag, " busy"}, 32'(busy), (i < 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        // Reset values
        #12;
        check_eq("rst we3", 32'(we3), 32'd0);
        check_eq("rst wa3", 32'(wa3), 32'd0);
        check_eq("rst wd3", 32'(wd3), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd1);
        check_eq("rst rdy0", 32'(req0_ready), 32'd0);
        check_eq("rst rdy1", 32'(req1_ready), 32'd0);
        check_eq("rst last_grant", 32'(last_grant), 32'd1);

        // Clear sequence after reset release
        @(negedge clk);
        reset = 1'b0;
        check_clear_run("clr0");
        @(negedge clk);
        check_eq("idle we3", 32'(we3), 32'd0);
        check_eq("idle busy", 32'(busy), 32'd0);

        // Single req0 write
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 8'hA5;
        #1;
        check_eq("r0 rdy0", 32'(req0_ready), 32'd1);
        check_eq("r0 rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        check_eq("r0 we3", 32'(we3), 32'd1);
        check_eq("r0 wa3", 32'(wa3), 32'd3);
        check_eq("r0 wd3", 32'(wd3), 32'hA5);
        check_eq("r0 last_grant", 32'(last_grant), 32'd0);
        @(negedge clk);
        check_eq("r0 we3 after", 32'(we3), 32'd0);

        // Dropped writes from req1: address 0 then 20
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 8'h33;
        #1;
        check_eq("drop0 rdy1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        check_eq("drop0 we3", 32'(we3), 32'd0);
        check_eq("drop0 last_grant", 32'(last_grant), 32'd1);
        req1_addr = 5'd20;
        #1;
        check_eq("drop20 rdy1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        check_eq("drop20 we3", 32'(we3), 32'd0);
        check_eq("drop20 last_grant", 32'(last_grant), 32'd1);

        // Sustained contention alternates starting with req0
        req0_valid = 1'b1;
        req0_addr  = 5'd4;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_addr  = 5'd5;
        req1_data  = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("cont rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("cont rdy1", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            check_eq("cont we3", 32'(we3), 32'd1);
            check_eq("cont wa3", 32'(wa3), (k % 2 == 0) ? 32'd4 : 32'd5);
            check_eq("cont wd3", 32'(wd3), (k % 2 == 0) ? 32'h11 : 32'h22);
            check_eq("cont last_grant", 32'(last_grant), (k % 2 == 0) ? 32'd0 : 32'd1);
        end

        // clear while both requesters wait
        clear = 1'b1;
        #1;
        check_eq("clr rdy0", 32'(req0_ready), 32'd0);
        check_eq("clr rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr busy", 32'(busy), 32'd1);
        check_eq("clr we3", 32'(we3), 32'd0);
        check_eq("clr hold rdy0", 32'(req0_ready), 32'd0);
        check_clear_run("clr1");
        // Pending requests served after the clear, req0 first
        #1;
        check_eq("post rdy0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        check_eq("post wa3 a", 32'(wa3), 32'd4);
        check_eq("post we3 a", 32'(we3), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("post wa3 b", 32'(wa3), 32'd5);
        check_eq("post wd3 b", 32'(wd3), 32'h22);

        // Reset in the middle of a clear run
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check_eq("mid wa3", 32'(wa3), 32'(i));
        end
        reset = 1'b1;
        #1;
        check_eq("mid rst we3", 32'(we3), 32'd0);
        check_eq("mid rst wa3", 32'(wa3), 32'd0);
        check_eq("mid rst wd3", 32'(wd3), 32'd0);
        check_eq("mid rst busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq("restart we3", 32'(we3), 32'd1);
            check_eq("restart wa3", 32'(wa3), 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
